// File: rtl/trace_pkg.sv
// Shared encodings and record sizing for the pipeline trace buffer.
// The state and mode values are visible to software, so their numeric values are fixed.
package trace_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  typedef enum logic [1:0] {
    MODE_CONTINUOUS = 2'd0,
    MODE_ONESHOT    = 2'd1,
    MODE_TRIGGER    = 2'd2
  } mode_t;

  localparam int NUM_CH_DEF = 5;
  localparam int DATA_W_DEF = 16;
  localparam int CNT_W_DEF  = 32;

  localparam int FLAG_HALT   = 0;
  localparam int FLAG_OPCODE = 1;
  localparam int FLAG_FUNCT  = 2;

  // A record is {timestamp, packed channels}.
  function automatic int rec_width(input int cnt_w, input int num_ch, input int data_w);
    return cnt_w + num_ch * data_w;
  endfunction

  localparam int REC_W = rec_width(CNT_W_DEF, NUM_CH_DEF, DATA_W_DEF);

  // Encoding 3 is not a separate mode; it behaves as one-shot.
  function automatic mode_t decode_mode(input logic [1:0] m);
    case (m)
      2'd0:    return MODE_CONTINUOUS;
      2'd2:    return MODE_TRIGGER;
      default: return MODE_ONESHOT;
    endcase
  endfunction

endpackage

// File: rtl/trace_ram.sv
// Trace storage: one synchronous write port and one asynchronous read port.
// The asynchronous read lets the buffer present its oldest entry with no added latency.
module trace_ram
  import trace_pkg::*;
#(
  parameter int DEPTH = 32,
  parameter int W     = REC_W,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic [AW-1:0] rd_addr,
  output logic [W-1:0]  rd_data
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/pipe_trace_buffer.sv
// Circular capture of timestamped pipeline probe snapshots, with sticky event flags
// and a show-ahead valid/ready readout port.
module pipe_trace_buffer
  import trace_pkg::*;
#(
  parameter int NUM_CH    = 5,
  parameter int DATA_W    = 16,
  parameter int DEPTH     = 32,
  parameter int CNT_W     = 32,
  parameter int POST_TRIG = 16
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             sample_en,
  input  logic [NUM_CH*DATA_W-1:0]         ch_data,
  input  logic [1:0]                       mode,
  input  logic                             arm,
  input  logic                             trigger,
  input  logic                             halt_in,
  input  logic                             opcode_err_in,
  input  logic                             funct_err_in,
  input  logic                             rd_ready,
  output logic                             rd_valid,
  output logic [CNT_W+NUM_CH*DATA_W-1:0]   rd_data,
  output logic [$clog2(DEPTH):0]           count,
  output logic [CNT_W-1:0]                 cycle_count,
  output logic [1:0]                       state,
  output logic [2:0]                       flags,
  output logic                             overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int RW = rec_width(CNT_W, NUM_CH, DATA_W);
  localparam int PW = $clog2(POST_TRIG + 1);
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);

  // Handshake: an entry transfers on a cycle where rd_valid and rd_ready are both high;
  // rd_data is stable while rd_valid is high and rd_ready is low.

  state_t        state_q, state_d;
  mode_t         mode_q;
  logic [AW-1:0] head_q, tail_q;
  logic [AW:0]   count_q, count_upd;
  logic [PW-1:0] post_q, post_d;
  logic [2:0]    flags_q;
  logic          ovf_q;
  logic [CNT_W-1:0] cyc_q;

  logic full, pop, wr_req, wr_en, overwrite, drop, adv_head;

  assign full     = (count_q == FULL);
  assign rd_valid = (count_q != '0);
  assign pop      = rd_valid && rd_ready && !arm;
  assign wr_req   = (state_q == ST_CAPTURE) && sample_en && !arm;

  // A pop in the same cycle frees a slot, so a full buffer only overwrites or drops without one.
  always_comb begin
    wr_en     = 1'b0;
    overwrite = 1'b0;
    drop      = 1'b0;
    if (wr_req) begin
      if (!full || pop) begin
        wr_en = 1'b1;
      end else if (mode_q == MODE_CONTINUOUS) begin
        wr_en     = 1'b1;
        overwrite = 1'b1;
      end else if (mode_q == MODE_TRIGGER) begin
        drop = 1'b1;
      end
    end
  end

  assign adv_head  = pop || overwrite;
  assign count_upd = count_q + (AW+1)'(wr_en) - (AW+1)'(adv_head);

  always_comb begin
    state_d = state_q;
    post_d  = post_q;
    if (arm) begin
      state_d = (decode_mode(mode) == MODE_TRIGGER) ? ST_ARMED : ST_CAPTURE;
    end else begin
      case (state_q)
        ST_ARMED: begin
          if (trigger) begin
            state_d = ST_CAPTURE;
            post_d  = PW'(POST_TRIG);
          end
        end
        ST_CAPTURE: begin
          if (mode_q == MODE_ONESHOT && wr_en && count_upd == FULL) state_d = ST_DONE;
          // Dropped samples still consume the post-trigger budget.
          if (mode_q == MODE_TRIGGER && wr_req) begin
            post_d = post_q - PW'(1);
            if (post_q == PW'(1)) state_d = ST_DONE;
          end
          if (halt_in) state_d = ST_DONE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      post_q  <= '0;
    end else begin
      state_q <= state_d;
      post_q  <= post_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mode_q  <= MODE_CONTINUOUS;
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      flags_q <= '0;
      ovf_q   <= 1'b0;
      cyc_q   <= '0;
    end else begin
      cyc_q <= cyc_q + CNT_W'(1);
      if (arm) begin
        mode_q  <= decode_mode(mode);
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
        flags_q <= '0;
        ovf_q   <= 1'b0;
      end else begin
        if (wr_en)    tail_q <= tail_q + AW'(1);
        if (adv_head) head_q <= head_q + AW'(1);
        count_q <= count_upd;
        if (overwrite || drop) ovf_q <= 1'b1;
        if (state_q != ST_IDLE) begin
          flags_q[FLAG_HALT]   <= flags_q[FLAG_HALT]   | halt_in;
          flags_q[FLAG_OPCODE] <= flags_q[FLAG_OPCODE] | opcode_err_in;
          flags_q[FLAG_FUNCT]  <= flags_q[FLAG_FUNCT]  | funct_err_in;
        end
      end
    end
  end

  trace_ram #(
    .DEPTH (DEPTH),
    .W     (RW)
  ) u_ram (
    .clk     (clk),
    .wr_en   (wr_en),
    .wr_addr (tail_q),
    .wr_data ({cyc_q, ch_data}),
    .rd_addr (head_q),
    .rd_data (rd_data)
  );

  assign count       = count_q;
  assign cycle_count = cyc_q;
  assign state       = state_q;
  assign flags       = flags_q;
  assign overflow    = ovf_q;

endmodule

// File: doc/pipe_trace_buffer.md
Name: pipe_trace_buffer

Overview:
- Synthesizable on-chip trace buffer that captures timestamped snapshots of pipeline probe channels (PC, instruction, stage values) into a circular memory.
- Replaces the per-cycle testbench printout with hardware capture: free-running, one-shot and triggered modes, sticky HALT/error event flags, and a valid/ready readout port.
- Sits beside the cpu top level; probe inputs are tapped from the IF/ID/EX/M/WB stage registers.

Parameters:
- NUM_CH, 5, number of probe channels (one per pipeline stage by default)
- DATA_W, 16, width of each channel
- DEPTH, 32, trace entries; power of two, >=2
- CNT_W, 32, cycle-counter and timestamp width
- POST_TRIG, 16, entries captured after trigger in TRIGGER mode; 1..DEPTH

Ports:
- clk in 1 system clock, rising edge
- reset in 1 asynchronous, active-low; 0 = in reset
- sample_en in 1 capture qualifier for this cycle
- ch_data in NUM_CH*DATA_W packed channels; ch0 in LSBs
- mode in 2 capture mode: 0 CONTINUOUS, 1 ONESHOT, 2 TRIGGER, 3 treated as ONESHOT
- arm in 1 single-cycle pulse; clears buffer and starts capture
- trigger in 1 trigger event (TRIGGER mode only)
- halt_in in 1 CPU HALT indication
- opcode_err_in in 1 unknown opcode indication
- funct_err_in in 1 unknown function code indication
- rd_ready in 1 consumer accepts rd_data
- rd_valid out 1 buffer non-empty
- rd_data out CNT_W+NUM_CH*DATA_W oldest entry {timestamp, ch_data}
- count out $clog2(DEPTH)+1 number of valid entries
- cycle_count out CNT_W free-running cycle counter
- state out 2 FSM state
- flags out 3 sticky {funct_err_seen, opcode_err_seen, halt_seen}
- overflow out 1 sticky; CONTINUOUS mode overwrote an unread entry

Behaviour:
- Reset (reset=0, asynchronous): state=IDLE; head, tail, count, flags, overflow, cycle_count all 0; rd_valid=0. Memory contents are don't-care.
- cycle_count: +1 every clk while reset=1; wraps at 2^CNT_W. Not cleared by arm. The timestamp written is the pre-increment value.
- Write condition: state==CAPTURE && sample_en && !arm. Writes to mem[tail]; tail+1 mod DEPTH.
- FSM states: IDLE=0, ARMED=1, CAPTURE=2, DONE=3.
  - IDLE: arm -> CAPTURE if mode!=2, else ARMED.
  - ARMED: no writes. trigger=1 -> CAPTURE, post-counter loaded with POST_TRIG. A trigger on the same cycle as arm is ignored.
  - CAPTURE, CONTINUOUS: never leaves on its own. Write when count==DEPTH and no pop: overwrite oldest, head+1, count unchanged, overflow<=1.
  - CAPTURE, ONESHOT: write while count<DEPTH. The write making count==DEPTH -> DONE. A write when full (due to prior reads) is impossible by construction.
  - CAPTURE, TRIGGER: each write decrements post-counter; the write reaching 0 -> DONE. If count==DEPTH, the write is dropped, overflow<=1, and post-counter still decrements.
  - CAPTURE, any mode: halt_in=1 -> DONE next cycle. A write qualified in the same cycle is still taken.
  - DONE: holds until arm. arm -> restart per mode.
- arm in any state:
  - Clears head, tail, count, overflow and flags.
  - Re-evaluates mode; mode is sampled only on arm.
  - Beats any same-cycle write or pop.
- Flags: set when the corresponding input is 1 while state!=IDLE; cleared only by arm or reset.
- Readout is show-ahead:
  - rd_valid = (count!=0); rd_data = mem[head] combinationally.
  - Pop when rd_valid && rd_ready: head+1. Allowed in every state.
  - Simultaneous write and pop: count unchanged. If full, no overwrite and no overflow.
- count: 0..DEPTH inclusive; pointers wrap modulo DEPTH.

Decomposition:
- Package trace_pkg holds:
  - state encodings IDLE/ARMED/CAPTURE/DONE
  - mode encodings CONTINUOUS/ONESHOT/TRIGGER
  - REC_W = CNT_W + NUM_CH*DATA_W
  - flag bit indices
- Sub-module trace_ram: DEPTH x REC_W, one synchronous write port, one asynchronous read port.
- FSM, pointers, counters and flags live in pipe_trace_buffer.

Test Plan (NUM_CH=2, DATA_W=8, DEPTH=4, CNT_W=16, POST_TRIG=3):
- Reset mid-capture: assert reset=0 asynchronously between edges -> same-instant state=0, count=0, rd_valid=0, cycle_count=0.
- ONESHOT: arm with mode=1, sample_en=1, ch_data=16'hA100+n for 6 cycles -> DONE after 4 writes, count=4. Reads return ch_data A100..A103 with strictly increasing timestamps; overflow=0.
- CONTINUOUS: mode=0, 6 writes of 16'h0001..16'h0006, no reads -> count=4, overflow=1, reads return 0003..0006.
- TRIGGER: mode=2, 2 samples before trigger -> count=0. trigger pulse then 5 samples -> DONE after 3 writes, count=3.
- HALT/errors: CAPTURE with opcode_err_in pulse, then halt_in with sample_en=1 -> flags=3'b011, that sample stored, state=DONE next cycle.
- Full-boundary concurrency: CONTINUOUS, count=4, write and pop same cycle -> count=4, overflow stays 0. A subsequent arm clears count, flags and overflow.
